timer_counter: RTL and testbench

- Memory-mapped countdown timer on the CPU data bus, downstream of the pipeline's M-stage data port (m_data_addr / m_data_wdata / m_data_byteen / m_data_rdata) through the system bridge.
- Three word registers: CTRL, PRESET and COUNT.
- A four-state FSM loads PRESET into COUNT, counts down to zero and raises an interrupt request toward the CPU.
- Supports one-shot and auto-reload modes.

---
 rtl/timer_counter_if.sv | 28 ++
 rtl/timer_counter.sv | 172 +++++++++++++++++
 tb/tb_timer_counter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/timer_counter_if.sv
// Bus-side signal bundle for the countdown timer: word select, byte-lane
// write strobe/data, combinational read data and the interrupt request.
interface timer_counter_if;
  logic [1:0]  addr;
  logic        we;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (
    output addr,
    output we,
    output byteen,
    output wdata,
    input  rdata,
    input  irq
  );

  modport slave (
    input  addr,
    input  we,
    input  byteen,
    input  wdata,
    output rdata,
    output irq
  );
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, a four-state
// load/count/interrupt FSM, one-shot and auto-reload modes.
module timer_counter #(
  parameter logic [31:0] PRESET_RST = 32'h0000_0000,
  parameter logic [1:0]  MODE_RST   = 2'b00
) (
  input  logic            clk,
  input  logic            reset,
  timer_counter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_CNT  = 2'b10,
    S_INT  = 2'b11
  } state_t;

  localparam logic [1:0] A_CTRL   = 2'b00;
  localparam logic [1:0] A_PRESET = 2'b01;
  localparam logic [1:0] A_COUNT  = 2'b10;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_en;
  logic [1:0]  r_mode;
  logic        r_im;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_irq_flag;

  logic        w_load;
  logic        w_dec;
  logic        w_set_flag;
  logic        w_clr_en;
  logic        w_reload_clr;
  logic        w_auto;
  logic        w_wr_ctrl;
  logic        w_wr_ctrl_b0;
  logic        w_wr_preset;

  function automatic logic [31:0] merge_lanes(
    input logic [31:0] old_val,
    input logic [31:0] new_val,
    input logic [3:0]  be
  );
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_val[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_val[8*i +: 8];
      end
    end
    return res;
  endfunction

  assign w_auto       = (r_mode == 2'b01);
  assign w_wr_ctrl    = bus.we && (bus.addr == A_CTRL) && (bus.byteen != 4'b0000);
  assign w_wr_ctrl_b0 = w_wr_ctrl && bus.byteen[0];
  assign w_wr_preset  = bus.we && (bus.addr == A_PRESET);

  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_dec        = 1'b0;
    w_set_flag   = 1'b0;
    w_clr_en     = 1'b0;
    w_reload_clr = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_en) begin
          w_state_nxt = S_LOAD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD: begin
        w_load      = 1'b1;
        w_state_nxt = S_CNT;
      end
      S_CNT: begin
        if (!r_en) begin
          w_state_nxt = S_IDLE;
        end else if (r_count == 32'd0) begin
          w_state_nxt = S_INT;
          w_set_flag  = 1'b1;
        end else begin
          w_dec = 1'b1;
        end
      end
      S_INT: begin
        if (w_auto) begin
          w_state_nxt  = S_LOAD;
          w_reload_clr = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
          w_clr_en    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A CPU write to CTRL lane 0 takes priority over the FSM clearing en.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en   <= 1'b0;
      r_mode <= MODE_RST;
      r_im   <= 1'b0;
    end else if (w_wr_ctrl_b0) begin
      r_en   <= bus.wdata[0];
      r_mode <= bus.wdata[2:1];
      r_im   <= bus.wdata[3];
    end else if (w_clr_en) begin
      r_en <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_preset <= PRESET_RST;
    end else if (w_wr_preset) begin
      r_preset <= merge_lanes(r_preset, bus.wdata, bus.byteen);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= 32'd0;
    end else if (w_load) begin
      r_count <= r_preset;
    end else if (w_dec) begin
      r_count <= r_count - 32'd1;
    end
  end

  // Setting the flag wins over a coincident CTRL write so no expiry is lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_irq_flag <= 1'b0;
    end else if (w_set_flag) begin
      r_irq_flag <= 1'b1;
    end else if (w_wr_ctrl || w_reload_clr) begin
      r_irq_flag <= 1'b0;
    end
  end

  always_comb begin
    bus.rdata = 32'h0000_0000;
    case (bus.addr)
      A_CTRL:   bus.rdata = {28'd0, r_im, r_mode, r_en};
      A_PRESET: bus.rdata = r_preset;
      A_COUNT:  bus.rdata = r_count;
      default:  bus.rdata = 32'h0000_0000;
    endcase
  end

  assign bus.irq = r_irq_flag & r_im;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter with hand-computed expected values.
module tb_timer_counter;

  localparam logic [1:0] A_CTRL   = 2'b00;
  localparam logic [1:0] A_PRESET = 2'b01;
  localparam logic [1:0] A_COUNT  = 2'b10;
  localparam logic [1:0] A_NONE   = 2'b11;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  timer_counter_if u_bus ();

  timer_counter #(
    .PRESET_RST (32'h0000_0000),
    .MODE_RST   (2'b00)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
    u_bus.addr   = a;
    u_bus.wdata  = d;
    u_bus.byteen = be;
    u_bus.we     = 1'b1;
    @(posedge clk);
    #1;
    u_bus.we     = 1'b0;
    u_bus.byteen = 4'b0000;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    u_bus.addr = a;
    #1;
    check(tag, u_bus.rdata, exp);
  endtask

  task automatic chk_irq(input logic exp, input string tag);
    check(tag, {31'd0, u_bus.irq}, {31'd0, exp});
  endtask

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    reset        = 1'b0;
    u_bus.addr   = 2'b00;
    u_bus.we     = 1'b0;
    u_bus.byteen = 4'b0000;
    u_bus.wdata  = 32'h0000_0000;

    // Reset values
    #1;
    rd(A_CTRL,   32'h0, "rst_ctrl");
    rd(A_PRESET, 32'h0, "rst_preset");
    rd(A_COUNT,  32'h0, "rst_count");
    rd(A_NONE,   32'h0, "rst_addr3");
    chk_irq(1'b0, "rst_irq");
    @(negedge clk);
    reset = 1'b1;
    tick(1);

    // One-shot, P=5
    wr(A_PRESET, 32'd5, 4'b1111);
    wr(A_CTRL, 32'h9, 4'b1111);
    tick(1);
    rd(A_COUNT, 32'd0, "os_e1_count");
    tick(1);
    rd(A_COUNT, 32'd5, "os_e2_count");
    for (int k = 3; k <= 7; k++) begin
      tick(1);
      rd(A_COUNT, 32'(7 - k), "os_count");
      chk_irq(1'b0, "os_irq_low");
    end
    tick(1);
    chk_irq(1'b1, "os_e8_irq");
    rd(A_CTRL, 32'h9, "os_e8_ctrl");
    tick(1);
    rd(A_CTRL, 32'h8, "os_en_cleared");
    chk_irq(1'b1, "os_e9_irq");
    tick(3);
    chk_irq(1'b1, "os_irq_hold");
    rd(A_COUNT, 32'd0, "os_count_floor");
    wr(A_CTRL, 32'h8, 4'b1111);
    chk_irq(1'b0, "os_irq_cleared");

    // Auto-reload, P=2: one-cycle pulse every 5 cycles
    wr(A_PRESET, 32'd2, 4'b1111);
    wr(A_CTRL, 32'hB, 4'b1111);
    for (int k = 1; k <= 17; k++) begin
      tick(1);
      chk_irq((k >= 5) && ((k - 5) % 5 == 0), "ar_irq");
      if ((k >= 2) && ((k - 2) % 5 == 0)) begin
        rd(A_COUNT, 32'd2, "ar_reload");
      end
    end
    wr(A_CTRL, 32'h0, 4'b1111);
    tick(1);
    rd(A_COUNT, 32'd1, "ar_stop_count");
    chk_irq(1'b0, "ar_stop_irq");

    // Byte lanes, no-op write, read-only COUNT, CTRL upper bits
    wr(A_PRESET, 32'h1122_3344, 4'b1111);
    wr(A_PRESET, 32'hAABB_CCDD, 4'b0100);
    rd(A_PRESET, 32'h11BB_3344, "be_lane2");
    wr(A_PRESET, 32'hFFFF_FFFF, 4'b0000);
    rd(A_PRESET, 32'h11BB_3344, "be_none");
    wr(A_COUNT, 32'hFFFF_FFFF, 4'b1111);
    rd(A_COUNT, 32'd1, "count_ro");
    wr(A_CTRL, 32'hFFFF_FFF6, 4'b1111);
    rd(A_CTRL, 32'h6, "ctrl_upper_zero");
    wr(A_CTRL, 32'h0, 4'b1111);

    // Mid-count disable, re-enable, async reset
    wr(A_PRESET, 32'd6, 4'b1111);
    wr(A_CTRL, 32'h1, 4'b1111);
    tick(4);
    rd(A_COUNT, 32'd4, "mid_count4");
    wr(A_CTRL, 32'h0, 4'b1111);
    rd(A_COUNT, 32'd3, "mid_count3");
    tick(3);
    rd(A_COUNT, 32'd3, "mid_frozen");
    rd(A_CTRL, 32'h0, "mid_ctrl");
    wr(A_CTRL, 32'h1, 4'b1111);
    tick(2);
    rd(A_COUNT, 32'd6, "mid_reload");
    tick(2);
    rd(A_COUNT, 32'd4, "mid_running");
    #2;
    reset = 1'b0;
    #1;
    rd(A_COUNT,  32'd0, "arst_count");
    rd(A_CTRL,   32'h0, "arst_ctrl");
    rd(A_PRESET, 32'h0, "arst_preset");
    chk_irq(1'b0, "arst_irq");
    @(negedge clk);
    reset = 1'b1;
    tick(3);
    rd(A_COUNT, 32'd0, "arst_idle");

    // P=0 and CTRL write racing the one-shot en clear
    wr(A_CTRL, 32'h9, 4'b1111);
    tick(2);
    chk_irq(1'b0, "p0_e2_irq");
    tick(1);
    chk_irq(1'b1, "p0_e3_irq");
    wr(A_CTRL, 32'h9, 4'b1111);
    rd(A_CTRL, 32'h9, "race_ctrl_kept");
    chk_irq(1'b0, "race_flag_clr");
    tick(3);
    chk_irq(1'b1, "race_rerun_irq");
    wr(A_CTRL, 32'h8, 4'b1111);
    chk_irq(1'b0, "race_final_clr");

    // Masked interrupt
    wr(A_CTRL, 32'h1, 4'b1111);
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      chk_irq(1'b0, "mask_irq");
    end
    rd(A_CTRL, 32'h0, "mask_en_cleared");
    wr(A_CTRL, 32'h8, 4'b1111);
    chk_irq(1'b0, "mask_unmask_irq");
    tick(1);
    chk_irq(1'b0, "mask_unmask_irq2");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
